// File: rtl/predict_resolve_queue_pkg.sv
// Shared definitions for the predict/resolve queue: default sizing and the
// packed entry layout {taken, provider} kept for each in-flight prediction.
package predict_resolve_queue_pkg;

    localparam int DEFAULT_DEPTH      = 8;
    localparam int DEFAULT_PROVIDER_W = 3;

    typedef struct packed {
        logic                          taken;
        logic [DEFAULT_PROVIDER_W-1:0] provider;
    } entry_t;

endpackage

// File: rtl/pred_fifo_mem.sv
// Register array holding the in-flight predictions: one synchronous write
// port at the tail and one asynchronous read port at the head. Contents are
// deliberately not reset; a slot is only read after it has been written.
module pred_fifo_mem #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write the pushed entry into the tail slot
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/predict_resolve_queue.sv
// In-order queue of branch predictions. Pushes record {taken, provider};
// each resolve pops the oldest entry and, one cycle later, strobes enable
// with the correctness of that prediction and its provider id.
module predict_resolve_queue
    import predict_resolve_queue_pkg::*;
#(
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int PROVIDER_W = DEFAULT_PROVIDER_W
) (
    input  logic                       Clk,
    input  logic                       reset,
    input  logic                       PredValid,
    input  logic                       PredTaken,
    input  logic [PROVIDER_W-1:0]      PredProvider,
    input  logic                       OutcomeValid,
    input  logic                       OutcomeTaken,
    output logic                       BranchResult,
    output logic                       enable,
    output logic [PROVIDER_W-1:0]      ResolvedProvider,
    output logic [$clog2(DEPTH):0]     Count,
    output logic                       Full,
    output logic                       Empty,
    output logic                       Overflow,
    output logic                       Underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Local entry layout follows the PROVIDER_W parameter of this instance
    typedef struct packed {
        logic                  taken;
        logic [PROVIDER_W-1:0] provider;
    } slot_t;

    logic [AW-1:0] head_ptr;
    logic [AW-1:0] tail_ptr;
    slot_t         wr_entry;
    slot_t         rd_entry;
    logic          push_ok;
    logic          pop_ok;

    assign Full  = (Count == CW'(DEPTH));
    assign Empty = (Count == '0);

    // A pop frees a slot this cycle, so a push into a full queue is still
    // accepted alongside it; an empty queue never bypasses a push to a pop.
    assign pop_ok  = OutcomeValid && !Empty;
    assign push_ok = PredValid && (!Full || pop_ok);

    assign wr_entry.taken    = PredTaken;
    assign wr_entry.provider = PredProvider;

    pred_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (1 + PROVIDER_W)
    ) u_mem (
        .clk     (Clk),
        .wr_en   (push_ok),
        .wr_addr (tail_ptr),
        .wr_data (wr_entry),
        .rd_addr (head_ptr),
        .rd_data (rd_entry)
    );

    // Pointer, occupancy and sticky error-flag bookkeeping
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            head_ptr  <= '0;
            tail_ptr  <= '0;
            Count     <= '0;
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
        end else begin
            if (push_ok) begin
                tail_ptr <= tail_ptr + AW'(1);
            end
            if (pop_ok) begin
                head_ptr <= head_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   Count <= Count + CW'(1);
                2'b01:   Count <= Count - CW'(1);
                default: Count <= Count;
            endcase
            if (PredValid && Full && !pop_ok) begin
                Overflow <= 1'b1;
            end
            if (OutcomeValid && Empty) begin
                Underflow <= 1'b1;
            end
        end
    end

    // Registered resolve result: strobe for one cycle, otherwise hold
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            enable           <= 1'b0;
            BranchResult     <= 1'b0;
            ResolvedProvider <= '0;
        end else begin
            enable <= pop_ok;
            if (pop_ok) begin
                BranchResult     <= (rd_entry.taken == OutcomeTaken);
                ResolvedProvider <= rd_entry.provider;
            end
        end
    end

endmodule

// File: tb/tb_predict_resolve_queue.sv
// Randomised and directed bench for predict_resolve_queue. A queue-based
// reference model predicts occupancy, flags and each resolve result; a
// separate monitor pops expected results as the strobes appear.
module tb_predict_resolve_queue;
    import predict_resolve_queue_pkg::*;

    localparam int DEPTH = 8;
    localparam int PW    = 3;

    logic          Clk = 1'b0;
    logic          reset = 1'b0;
    logic          PredValid = 1'b0;
    logic          PredTaken = 1'b0;
    logic [PW-1:0] PredProvider = '0;
    logic          OutcomeValid = 1'b0;
    logic          OutcomeTaken = 1'b0;
    logic          BranchResult;
    logic          enable;
    logic [PW-1:0] ResolvedProvider;
    logic [3:0]    Count;
    logic          Full;
    logic          Empty;
    logic          Overflow;
    logic          Underflow;

    typedef struct {
        logic          result;
        logic [PW-1:0] provider;
    } expect_t;

    entry_t        model_q[$];
    expect_t       exp_q[$];
    logic          model_ovf = 1'b0;
    logic          model_unf = 1'b0;
    logic          last_br = 1'b0;
    logic [PW-1:0] last_rp = '0;
    int            total = 0;
    int            bad = 0;

    predict_resolve_queue #(
        .DEPTH      (DEPTH),
        .PROVIDER_W (PW)
    ) dut (
        .Clk              (Clk),
        .reset            (reset),
        .PredValid        (PredValid),
        .PredTaken        (PredTaken),
        .PredProvider     (PredProvider),
        .OutcomeValid     (OutcomeValid),
        .OutcomeTaken     (OutcomeTaken),
        .BranchResult     (BranchResult),
        .enable           (enable),
        .ResolvedProvider (ResolvedProvider),
        .Count            (Count),
        .Full             (Full),
        .Empty            (Empty),
        .Overflow         (Overflow),
        .Underflow        (Underflow)
    );

    always #5 Clk = ~Clk;

    task automatic compare(input string name, input int actual, input int required);
        total++;
        if (actual != required) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, want %0d at %0t", name, actual, required, $time);
        end
    endtask

    // Occupancy and flags against the model's view of the queue
    task automatic check_output();
        compare("count", int'(Count), model_q.size());
        compare("full", int'(Full), (model_q.size() == DEPTH) ? 1 : 0);
        compare("empty", int'(Empty), (model_q.size() == 0) ? 1 : 0);
        compare("overflow", int'(Overflow), int'(model_ovf));
        compare("underflow", int'(Underflow), int'(model_unf));
    endtask

    task automatic clear_model();
        model_q.delete();
        exp_q.delete();
        model_ovf = 1'b0;
        model_unf = 1'b0;
        last_br   = 1'b0;
        last_rp   = '0;
    endtask

    // Reference behaviour: FIFO of predictions, judged when the oldest resolves
    task automatic model_step(input logic pv, input logic pt, input logic [PW-1:0] pp,
                              input logic ov, input logic ot);
        bit was_full  = (model_q.size() == DEPTH);
        bit was_empty = (model_q.size() == 0);
        bit pop       = ov && !was_empty;
        bit push      = pv && (!was_full || pop);
        entry_t e;
        expect_t x;
        if (pv && was_full && !pop) model_ovf = 1'b1;
        if (ov && was_empty) model_unf = 1'b1;
        if (pop) begin
            e = model_q.pop_front();
            x.result   = (e.taken == ot);
            x.provider = e.provider;
            exp_q.push_back(x);
        end
        if (push) begin
            e.taken    = pt;
            e.provider = pp;
            model_q.push_back(e);
        end
    endtask

    // One clock of stimulus, driven on the falling edge; also releases reset
    task automatic apply_stimulus(input logic pv, input logic pt, input logic [PW-1:0] pp,
                                  input logic ov, input logic ot);
        @(negedge Clk);
        reset = 1'b1;
        check_output();
        PredValid    = pv;
        PredTaken    = pt;
        PredProvider = pp;
        OutcomeValid = ov;
        OutcomeTaken = ot;
        model_step(pv, pt, pp, ov, ot);
    endtask

    task automatic idle_inputs();
        PredValid    = 1'b0;
        PredTaken    = 1'b0;
        PredProvider = '0;
        OutcomeValid = 1'b0;
        OutcomeTaken = 1'b0;
    endtask

    // Holds reset over a rising edge; the next apply_stimulus releases it
    task automatic do_reset();
        @(negedge Clk);
        reset = 1'b0;
        idle_inputs();
        clear_model();
        @(posedge Clk);
        #1;
        compare("rst_enable", int'(enable), 0);
        compare("rst_branch_result", int'(BranchResult), 0);
        compare("rst_provider", int'(ResolvedProvider), 0);
        compare("rst_count", int'(Count), 0);
        compare("rst_empty", int'(Empty), 1);
        compare("rst_full", int'(Full), 0);
        compare("rst_overflow", int'(Overflow), 0);
        compare("rst_underflow", int'(Underflow), 0);
    endtask

    // Monitor: every strobe is matched against the oldest expected result
    initial begin
        expect_t e;
        bit due;
        forever begin
            @(posedge Clk);
            #1;
            due = (exp_q.size() > 0);
            compare("enable", int'(enable), due ? 1 : 0);
            if (due) e = exp_q.pop_front();
            if (enable && due) begin
                compare("branch_result", int'(BranchResult), int'(e.result));
                compare("resolved_provider", int'(ResolvedProvider), int'(e.provider));
                last_br = e.result;
                last_rp = e.provider;
            end else if (!enable) begin
                compare("hold_branch_result", int'(BranchResult), int'(last_br));
                compare("hold_provider", int'(ResolvedProvider), int'(last_rp));
            end
        end
    end

    initial begin
        int pv_pct;
        int ov_pct;

        do_reset();
        apply_stimulus(1, 1, 3'd2, 0, 0);
        apply_stimulus(0, 0, 3'd0, 1, 1);
        apply_stimulus(0, 0, 3'd0, 0, 0);
        apply_stimulus(0, 0, 3'd0, 0, 0);

        apply_stimulus(1, 0, 3'd1, 0, 0);
        apply_stimulus(1, 1, 3'd4, 0, 0);
        apply_stimulus(1, 0, 3'd6, 0, 0);
        apply_stimulus(0, 0, 3'd0, 1, 1);
        apply_stimulus(0, 0, 3'd0, 1, 1);
        apply_stimulus(0, 0, 3'd0, 1, 0);
        apply_stimulus(0, 0, 3'd0, 0, 0);

        for (int i = 0; i < 9; i++) apply_stimulus(1, i[0], 3'(i), 0, 0);
        apply_stimulus(0, 0, 3'd0, 0, 0);
        for (int i = 0; i < 8; i++) apply_stimulus(0, 0, 3'd0, 1, i[1]);
        apply_stimulus(0, 0, 3'd0, 0, 0);

        do_reset();
        for (int i = 0; i < 8; i++) apply_stimulus(1, i[1], 3'(7 - i), 0, 0);
        for (int i = 0; i < 5; i++) apply_stimulus(1, i[0], 3'(i + 3), 1, i[0]);
        for (int i = 0; i < 8; i++) apply_stimulus(0, 0, 3'd0, 1, 1);
        apply_stimulus(0, 0, 3'd0, 0, 0);

        do_reset();
        apply_stimulus(1, 1, 3'd5, 1, 1);
        apply_stimulus(0, 0, 3'd0, 0, 0);
        apply_stimulus(0, 0, 3'd0, 1, 0);
        apply_stimulus(0, 0, 3'd0, 0, 0);

        do_reset();
        apply_stimulus(1, 1, 3'd1, 0, 0);
        apply_stimulus(1, 0, 3'd2, 0, 0);
        apply_stimulus(1, 1, 3'd3, 0, 0);
        @(negedge Clk);
        reset = 1'b1;
        check_output();
        OutcomeValid = 1'b1;
        OutcomeTaken = 1'b1;
        PredValid    = 1'b0;
        #2;
        reset = 1'b0;
        clear_model();
        idle_inputs();
        @(posedge Clk);
        #1;
        compare("abort_enable", int'(enable), 0);
        compare("abort_count", int'(Count), 0);
        compare("abort_overflow", int'(Overflow), 0);
        compare("abort_underflow", int'(Underflow), 0);

        for (int phase = 0; phase < 3; phase++) begin
            pv_pct = (phase == 0) ? 75 : (phase == 1) ? 25 : 50;
            ov_pct = (phase == 0) ? 30 : (phase == 1) ? 75 : 50;
            for (int i = 0; i < 600; i++) begin
                apply_stimulus(($urandom_range(0, 99) < pv_pct) ? 1'b1 : 1'b0,
                               1'($urandom), 3'($urandom),
                               ($urandom_range(0, 99) < ov_pct) ? 1'b1 : 1'b0,
                               1'($urandom));
            end
        end
        apply_stimulus(0, 0, 3'd0, 0, 0);
        apply_stimulus(0, 0, 3'd0, 0, 0);
        @(negedge Clk);
        compare("pending_strobes", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
